// File: rtl/vigna_clint_pkg.sv
// Shared constants, bus FSM state type and byte-lane merge helper for vigna_clint.
// Optional prescaler is enabled with VIGNA_CLINT_PRESCALE_EN.
package vigna_clint_pkg;

  localparam int MTIME_W = 64;

  localparam logic [4:0] CLINT_MSIP        = 5'h00;
  localparam logic [4:0] CLINT_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] CLINT_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] CLINT_MTIME_LO    = 5'h10;
  localparam logic [4:0] CLINT_MTIME_HI    = 5'h14;
  localparam logic [4:0] CLINT_PRESCALE    = 5'h18;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

  function automatic logic [31:0] strobe_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vigna_clint_timer.sv
// 64-bit mtime/mtimecmp pair with byte-strobed writes and registered compare.
// With VIGNA_CLINT_PRESCALE_EN a 16-bit prescaler gates the mtime tick.
module vigna_clint_timer
  import vigna_clint_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic [2:0]         wr_word,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  output logic [MTIME_W-1:0] mtime,
  output logic [MTIME_W-1:0] mtimecmp,
`ifdef VIGNA_CLINT_PRESCALE_EN
  output logic [15:0]        prescale,
`endif
  output logic               timer_irq
);

  logic [MTIME_W-1:0] mtime_r;
  logic [MTIME_W-1:0] mtimecmp_r;
  logic               timer_irq_r;
  logic               tick_s;
  logic               wr_mtime_lo_s, wr_mtime_hi_s, wr_cmp_lo_s, wr_cmp_hi_s;

  assign wr_mtime_lo_s = wr_en && (wr_word == CLINT_MTIME_LO[4:2]);
  assign wr_mtime_hi_s = wr_en && (wr_word == CLINT_MTIME_HI[4:2]);
  assign wr_cmp_lo_s   = wr_en && (wr_word == CLINT_MTIMECMP_LO[4:2]);
  assign wr_cmp_hi_s   = wr_en && (wr_word == CLINT_MTIMECMP_HI[4:2]);

`ifdef VIGNA_CLINT_PRESCALE_EN
  logic [15:0] prescale_r;
  logic [15:0] pre_cnt_r;
  logic        wr_pre_s;

  assign wr_pre_s = wr_en && (wr_word == CLINT_PRESCALE[4:2]);
  assign tick_s   = (pre_cnt_r == prescale_r);
  assign prescale = prescale_r;

  // Prescale register and divider counter; a new divisor restarts the count
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prescale_r <= 16'h0000;
      pre_cnt_r  <= 16'h0000;
    end else if (wr_pre_s) begin
      prescale_r <= {wstrb[1] ? wdata[15:8] : prescale_r[15:8],
                     wstrb[0] ? wdata[7:0]  : prescale_r[7:0]};
      pre_cnt_r  <= 16'h0000;
    end else if (tick_s) begin
      pre_cnt_r  <= 16'h0000;
    end else begin
      pre_cnt_r  <= pre_cnt_r + 16'h0001;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // mtime counter: a bus write to either half wins over the tick, with no carry that cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mtime_r <= {MTIME_W{1'b0}};
    end else if (wr_mtime_lo_s) begin
      mtime_r[31:0] <= strobe_merge(mtime_r[31:0], wdata, wstrb);
    end else if (wr_mtime_hi_s) begin
      mtime_r[63:32] <= strobe_merge(mtime_r[63:32], wdata, wstrb);
    end else if (tick_s) begin
      mtime_r <= mtime_r + 64'd1;
    end else begin
      mtime_r <= mtime_r;
    end
  end

  // mtimecmp byte-strobed writes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mtimecmp_r <= {MTIME_W{1'b1}};
    end else if (wr_cmp_lo_s) begin
      mtimecmp_r[31:0] <= strobe_merge(mtimecmp_r[31:0], wdata, wstrb);
    end else if (wr_cmp_hi_s) begin
      mtimecmp_r[63:32] <= strobe_merge(mtimecmp_r[63:32], wdata, wstrb);
    end else begin
      mtimecmp_r <= mtimecmp_r;
    end
  end

  // Registered unsigned compare drives the timer interrupt level
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer_irq_r <= 1'b0;
    end else begin
      timer_irq_r <= (mtime_r >= mtimecmp_r);
    end
  end

  assign mtime     = mtime_r;
  assign mtimecmp  = mtimecmp_r;
  assign timer_irq = timer_irq_r;

endmodule

// File: rtl/vigna_clint.sv
// Core-local interruptor: bus FSM, read mux and msip around vigna_clint_timer.
// Define VIGNA_CLINT_PRESCALE_EN to add the prescale register at offset 0x18.
module vigna_clint #(
  parameter int MTIME_W = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic [31:0] bus_rdata,
  output logic        timer_irq,
  output logic        soft_irq
);

  import vigna_clint_pkg::*;

  bus_state_e         state_r;
  logic               bus_ready_r;
  logic [31:0]        bus_rdata_r;
  logic               msip_r;
  logic               soft_irq_r;
  logic [31:0]        rdata_s;
  logic               accept_s;
  logic               wr_en_s;
  logic [2:0]         word_s;
  logic [MTIME_W-1:0] mtime_s;
  logic [MTIME_W-1:0] mtimecmp_s;
  logic               timer_irq_s;
  logic               unused_addr_s;
`ifdef VIGNA_CLINT_PRESCALE_EN
  logic [15:0]        prescale_s;
`endif

  assign word_s        = bus_addr[4:2];
  assign unused_addr_s = ^bus_addr[1:0];
  assign accept_s      = (state_r == ST_IDLE) && bus_valid && !bus_ready_r;
  assign wr_en_s       = accept_s && (bus_wstrb != 4'h0);

  vigna_clint_timer u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en_s),
    .wr_word   (word_s),
    .wdata     (bus_wdata),
    .wstrb     (bus_wstrb),
    .mtime     (mtime_s),
    .mtimecmp  (mtimecmp_s),
`ifdef VIGNA_CLINT_PRESCALE_EN
    .prescale  (prescale_s),
`endif
    .timer_irq (timer_irq_s)
  );

  // Read mux over the pre-edge register values
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (word_s)
      CLINT_MSIP[4:2]:        rdata_s = {31'h0000_0000, msip_r};
      CLINT_MTIMECMP_LO[4:2]: rdata_s = mtimecmp_s[31:0];
      CLINT_MTIMECMP_HI[4:2]: rdata_s = mtimecmp_s[MTIME_W-1:32];
      CLINT_MTIME_LO[4:2]:    rdata_s = mtime_s[31:0];
      CLINT_MTIME_HI[4:2]:    rdata_s = mtime_s[MTIME_W-1:32];
`ifdef VIGNA_CLINT_PRESCALE_EN
      CLINT_PRESCALE[4:2]:    rdata_s = {16'h0000, prescale_s};
`endif
      default:                rdata_s = 32'h0000_0000;
    endcase
  end

  // Bus FSM: one-cycle response, msip commits on the accepting edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      bus_ready_r <= 1'b0;
      bus_rdata_r <= 32'h0000_0000;
      msip_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_RESP;
            bus_ready_r <= 1'b1;
            bus_rdata_r <= rdata_s;
            if (wr_en_s && (word_s == CLINT_MSIP[4:2]) && bus_wstrb[0]) begin
              msip_r <= bus_wdata[0];
            end else begin
              msip_r <= msip_r;
            end
          end else begin
            state_r     <= ST_IDLE;
            bus_ready_r <= 1'b0;
          end
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          bus_ready_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          bus_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Software interrupt output follows msip one cycle later
  always_ff @(posedge clk) begin
    if (!resetn) begin
      soft_irq_r <= 1'b0;
    end else begin
      soft_irq_r <= msip_r;
    end
  end

  assign bus_ready = bus_ready_r;
  assign bus_rdata = bus_rdata_r;
  assign timer_irq = timer_irq_s;
  assign soft_irq  = soft_irq_r;

endmodule

// File: tb/tb_vigna_clint.sv
// Directed, table-driven bench for vigna_clint; expectations honour VIGNA_CLINT_PRESCALE_EN.
module tb_vigna_clint;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_ready;
  logic [4:0]  bus_addr = 5'h00;
  logic [31:0] bus_wdata = 32'h0;
  logic [3:0]  bus_wstrb = 4'h0;
  logic [31:0] bus_rdata;
  logic        timer_irq;
  logic        soft_irq;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  vigna_clint dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_rdata (bus_rdata),
    .timer_irq (timer_irq),
    .soft_irq  (soft_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus transaction, started just after a rising edge; returns 1 ns after the ready edge
  task automatic bus_access(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd);
    int lat;
    bus_addr  = a;
    bus_wdata = d;
    bus_wstrb = s;
    bus_valid = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus_ready && lat < 8);
    if (!bus_ready) begin
      checks++;
      $display("FAIL bus_timeout: no bus_ready at addr 0x%02h after %0d cycles, required within 8", a, lat);
    end
    rd        = bus_rdata;
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
  endtask

  initial begin
    logic [31:0] rd, r1, r2;
    logic [31:0] t[5];
    int rise_n, extra, bad;

    vecs[0]  = '{5'h00, 32'h0,         4'h0, 1'b1, 32'h0000_0000, "msip_rst"};
    vecs[1]  = '{5'h08, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFFF, "cmp_lo_rst"};
    vecs[2]  = '{5'h0C, 32'h0,         4'h0, 1'b1, 32'hFFFF_FFFF, "cmp_hi_rst"};
    vecs[3]  = '{5'h18, 32'h0,         4'h0, 1'b1, 32'h0000_0000, "off18_rst"};
    vecs[4]  = '{5'h1C, 32'h0,         4'h0, 1'b1, 32'h0000_0000, "unmapped_1c"};
    vecs[5]  = '{5'h04, 32'h0,         4'h0, 1'b1, 32'h0000_0000, "unmapped_04"};
    vecs[6]  = '{5'h08, 32'hAABB_CCDD, 4'h2, 1'b0, 32'h0,         "wr_cmp_lo_b1"};
    vecs[7]  = '{5'h08, 32'h0,         4'h0, 1'b1, 32'hFFFF_CCFF, "cmp_lo_byte1"};
    vecs[8]  = '{5'h0C, 32'hA1B2_C3D4, 4'h9, 1'b0, 32'h0,         "wr_cmp_hi_b03"};
    vecs[9]  = '{5'h0C, 32'h0,         4'h0, 1'b1, 32'hA1FF_FFD4, "cmp_hi_bytes"};
    vecs[10] = '{5'h00, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         "wr_msip_all"};
    vecs[11] = '{5'h00, 32'h0,         4'h0, 1'b1, 32'h0000_0001, "msip_set"};
    vecs[12] = '{5'h00, 32'h0,         4'h1, 1'b0, 32'h0,         "wr_msip_0"};
    vecs[13] = '{5'h00, 32'h0,         4'h0, 1'b1, 32'h0000_0000, "msip_clr"};
    vecs[14] = '{5'h1C, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         "wr_unmapped"};
    vecs[15] = '{5'h1C, 32'h0,         4'h0, 1'b1, 32'h0000_0000, "unmapped_wr"};
    vecs[16] = '{5'h10, 32'h0000_0100, 4'hF, 1'b0, 32'h0,         "wr_mtime_lo"};
    vecs[17] = '{5'h10, 32'h0,         4'h0, 1'b1, 32'h0000_0101, "mtime_wr_no_inc"};
    vecs[18] = '{5'h10, 32'h0000_5500, 4'h2, 1'b0, 32'h0,         "wr_mtime_b1"};
    vecs[19] = '{5'h10, 32'h0,         4'h0, 1'b1, 32'h0000_5504, "mtime_byte1"};
    vecs[20] = '{5'h0B, 32'h0,         4'h0, 1'b1, 32'hFFFF_CCFF, "addr_lowbits"};
    vecs[21] = '{5'h14, 32'h0,         4'h0, 1'b1, 32'h0000_0000, "mtime_hi"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, bus_ready}, 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_timer_irq", {31'h0, timer_irq}, 32'h0);
    check("rst_soft_irq", {31'h0, soft_irq}, 32'h0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (timer_irq || soft_irq) bad++;
    end
    check("idle_irqs_100", bad, 32'h0);

    // Register map table
    for (int i = 0; i < NV; i++) begin
      bus_access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd);
      if (vecs[i].chk) check(vecs[i].name, rd, vecs[i].exp);
    end

    // Single ready pulse
    bus_access(5'h1C, 32'h0, 4'h0, rd);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_ready) extra++;
    end
    check("ready_single", extra, 32'h0);

    // mtime advances one per cycle: back-to-back reads are 2 cycles apart
    bus_access(5'h10, 32'h0, 4'h0, r1);
    bus_access(5'h10, 32'h0, 4'h0, r2);
    check("mtime_step", r2 - r1, 32'd2);

    // soft_irq lags msip by one cycle
    bus_access(5'h00, 32'h1, 4'h1, rd);
    check("soft_lag", {31'h0, soft_irq}, 32'h0);
    step();
    check("soft_set", {31'h0, soft_irq}, 32'h1);
    bus_access(5'h00, 32'h0, 4'h1, rd);
    step();
    check("soft_clr", {31'h0, soft_irq}, 32'h0);

    // Timer compare at 0x40
    bus_access(5'h0C, 32'h0, 4'hF, rd);
    bus_access(5'h08, 32'h40, 4'hF, rd);
    bus_access(5'h14, 32'h0, 4'hF, rd);
    bus_access(5'h10, 32'h30, 4'hF, rd);
    rise_n = 0;
    for (int n = 1; n <= 40 && rise_n == 0; n++) begin
      step();
      if (n == 1) check("irq_low_after_mtime_wr", {31'h0, timer_irq}, 32'h0);
      if (timer_irq) rise_n = n;
    end
    check("irq_rise_cycle", rise_n, 32'd17);
    bus_access(5'h0C, 32'hFFFF_FFFF, 4'hF, rd);
    step();
    step();
    check("irq_fall_2cyc", {31'h0, timer_irq}, 32'h0);

    // 64-bit wrap with cmp = all-ones
    bus_access(5'h08, 32'hFFFF_FFFF, 4'hF, rd);
    bus_access(5'h14, 32'hFFFF_FFFF, 4'hF, rd);
    bus_access(5'h10, 32'hFFFF_FFFE, 4'hF, rd);
    step();
    check("wrap_irq_fe", {31'h0, timer_irq}, 32'h0);
    step();
    check("wrap_irq_max", {31'h0, timer_irq}, 32'h1);
    step();
    check("wrap_irq_zero", {31'h0, timer_irq}, 32'h0);
    bus_access(5'h14, 32'h0, 4'h0, rd);
    check("wrap_hi", rd, 32'h0);
    bus_access(5'h10, 32'h0, 4'h0, rd);
    check("wrap_lo", rd, 32'd3);

    // Prescale = 3 (unmapped in the default build)
    bus_access(5'h18, 32'h3, 4'hF, rd);
    bus_access(5'h18, 32'h0, 4'h0, rd);
`ifdef VIGNA_CLINT_PRESCALE_EN
    check("prescale_rd", rd, 32'h3);
`else
    check("prescale_rd", rd, 32'h0);
`endif
    for (int i = 0; i < 5; i++) bus_access(5'h10, 32'h0, 4'h0, t[i]);
`ifdef VIGNA_CLINT_PRESCALE_EN
    check("mtime_prescaled", t[4] - t[0], 32'd2);
`else
    check("mtime_prescaled", t[4] - t[0], 32'd8);
`endif

    // Reset while in RESP, and a pending write aborted by reset
    bus_access(5'h00, 32'h1, 4'h1, rd);
    bus_addr  = 5'h0C;
    bus_wstrb = 4'h0;
    bus_valid = 1'b1;
    step();
    step();
    check("resp_entered", {31'h0, bus_ready}, 32'h1);
    resetn    = 1'b0;
    bus_valid = 1'b0;
    step();
    check("rst_in_resp_ready", {31'h0, bus_ready}, 32'h0);
    check("rst_in_resp_rdata", bus_rdata, 32'h0);
    bus_addr  = 5'h00;
    bus_wdata = 32'h1;
    bus_wstrb = 4'h1;
    bus_valid = 1'b1;
    step();
    step();
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
    check("rst_soft_irq2", {31'h0, soft_irq}, 32'h0);
    check("rst_timer_irq2", {31'h0, timer_irq}, 32'h0);
    resetn = 1'b1;
    bus_access(5'h10, 32'h0, 4'h0, rd);
    check("post_rst_mtime", rd, 32'h0);
    bus_access(5'h00, 32'h0, 4'h0, rd);
    check("post_rst_msip", rd, 32'h0);
    bus_access(5'h08, 32'h0, 4'h0, rd);
    check("post_rst_cmp_lo", rd, 32'hFFFF_FFFF);
    bus_access(5'h0C, 32'h0, 4'h0, rd);
    check("post_rst_cmp_hi", rd, 32'hFFFF_FFFF);
    bus_access(5'h18, 32'h0, 4'h0, rd);
    check("post_rst_prescale", rd, 32'h0);
    bus_access(5'h10, 32'h0, 4'h0, r1);
    bus_access(5'h10, 32'h0, 4'h0, r2);
    check("post_rst_mtime_step", r2 - r1, 32'd2);
    step();
    check("post_rst_soft_irq", {31'h0, soft_irq}, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
